// File: rtl/game_pkg.sv
// Shared definitions for the game control slice: state encodings,
// coordinate width and the road-boundary test.
package game_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Both edges are on-road; an inverted road has no on-road position.
  function automatic logic is_off_road(input logic [COORD_W-1:0] x,
                                       input logic [COORD_W-1:0] left,
                                       input logic [COORD_W-1:0] right);
    return (x < left) || (x > right) || (left > right);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a stability debouncer; rise pulses for
// one cycle when the debounced level goes 0->1.
module button_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // r_cnt counts consecutive synchronized samples that disagree with r_level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow controller: IDLE -> RUN on start press, RUN -> HOLD after a run
// of off-road frames, HOLD -> IDLE after a fixed number of frames.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int GRACE_FRAMES = 3,
  parameter int HOLD_FRAMES  = 120,
  parameter int DEB_CYCLES   = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] road_left,
  input  logic [COORD_W-1:0] road_right,
  output logic               dead,
  output logic               running,
  output logic [1:0]         state,
  output logic [7:0]         crash_count
);

  localparam logic [7:0]  GRACE_MAX = 8'(GRACE_FRAMES);
  localparam logic [11:0] HOLD_MAX  = 12'(HOLD_FRAMES);

  logic   w_btn_level;
  logic   w_btn_rise;
  logic   w_start_press;
  logic   w_off_road;

  state_t r_state;
  logic [7:0]  r_off_cnt;
  logic [11:0] r_hold_cnt;
  logic        r_dead;
  logic        r_running;
  logic [7:0]  r_crash_count;

  state_t      w_state_next;
  logic [7:0]  w_off_next;
  logic [11:0] w_hold_next;
  logic        w_crash;
  logic        w_dead_next;
  logic        w_running_next;
  logic [7:0]  w_crash_count_next;

  button_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_start_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_in (start_btn),
    .level  (w_btn_level),
    .rise   (w_btn_rise)
  );

  assign w_start_press = w_btn_rise & w_btn_level;
  assign w_off_road    = is_off_road(player_x, road_left, road_right);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_off_cnt     <= '0;
      r_hold_cnt    <= '0;
      r_dead        <= 1'b0;
      r_running     <= 1'b0;
      r_crash_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_off_cnt     <= w_off_next;
      r_hold_cnt    <= w_hold_next;
      r_dead        <= w_dead_next;
      r_running     <= w_running_next;
      r_crash_count <= w_crash_count_next;
    end
  end

  // In IDLE the press wins over a coincident tick: the tick is never evaluated.
  always_comb begin
    w_state_next = r_state;
    w_off_next   = r_off_cnt;
    w_hold_next  = r_hold_cnt;
    w_crash      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_press) begin
          w_state_next = ST_RUN;
          w_off_next   = '0;
        end
      end
      ST_RUN: begin
        if (frame_tick) begin
          if (w_off_road) begin
            if (r_off_cnt < GRACE_MAX) begin
              w_off_next = r_off_cnt + 8'd1;
            end
            if (w_off_next == GRACE_MAX) begin
              w_state_next = ST_HOLD;
              w_hold_next  = '0;
              w_crash      = 1'b1;
            end
          end else begin
            w_off_next = '0;
          end
        end
      end
      ST_HOLD: begin
        if (frame_tick) begin
          if (r_hold_cnt < HOLD_MAX) begin
            w_hold_next = r_hold_cnt + 12'd1;
          end
          if (w_hold_next == HOLD_MAX) begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // dead is only raised on the RUN->HOLD edge, so it covers the first HOLD cycle only.
  always_comb begin
    w_dead_next        = w_crash;
    w_running_next     = (w_state_next == ST_RUN);
    w_crash_count_next = w_crash ? (r_crash_count + 8'd1) : r_crash_count;
  end

  assign dead        = r_dead;
  assign running     = r_running;
  assign state       = r_state;
  assign crash_count = r_crash_count;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Randomized and directed bench for game_state_ctrl against a cycle-level
// behavioural model of the game rules and the button filter.
module tb_game_state_ctrl;

  localparam int DEB   = 4;
  localparam int GRACE = 3;
  localparam int HOLD  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic [9:0] player_x = 10'd0;
  logic [9:0] road_left = 10'd0;
  logic [9:0] road_right = 10'd0;
  logic       dead;
  logic       running;
  logic [1:0] state;
  logic [7:0] crash_count;

  game_state_ctrl #(
    .GRACE_FRAMES(GRACE),
    .HOLD_FRAMES (HOLD),
    .DEB_CYCLES  (DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .player_x   (player_x),
    .road_left  (road_left),
    .road_right (road_right),
    .dead       (dead),
    .running    (running),
    .state      (state),
    .crash_count(crash_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: states as the numbers 0/1/2, counters as plain ints.
  int m_state, m_off, m_hold, m_crash;
  bit m_dead, m_press, m_level;
  bit raw_q[$];
  bit seen_q[$];

  wire [11:0] dut_vec = {dead, running, state, crash_count};

  function automatic bit off_road(int x, int l, int r);
    return (x < l) || (x > r) || (l > r);
  endfunction

  function automatic logic [11:0] exp_vec();
    return {m_dead, (m_state == 1), 2'(m_state), 8'(m_crash)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_off = 0; m_hold = 0; m_crash = 0;
    m_dead = 0; m_press = 0; m_level = 0;
    raw_q.delete();
    seen_q.delete();
  endtask

  task automatic model_edge();
    bit d_n = 0;
    bit s;
    bit all_same;
    if (m_state == 0) begin
      if (m_press) begin m_state = 1; m_off = 0; end
    end else if (m_state == 1) begin
      if (frame_tick) begin
        if (off_road(int'(player_x), int'(road_left), int'(road_right))) begin
          m_off = (m_off < GRACE) ? m_off + 1 : GRACE;
          if (m_off == GRACE) begin
            m_state = 2; m_hold = 0; d_n = 1; m_crash = (m_crash + 1) % 256;
          end
        end else begin
          m_off = 0;
        end
      end
    end else if (frame_tick) begin
      m_hold = (m_hold < HOLD) ? m_hold + 1 : HOLD;
      if (m_hold == HOLD) m_state = 0;
    end
    m_dead = d_n;
    // The filter sees the button as it was two edges ago.
    s = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 1'b0;
    raw_q.push_back(start_btn);
    seen_q.push_back(s);
    if (raw_q.size() > 8) void'(raw_q.pop_front());
    if (seen_q.size() > 8) void'(seen_q.pop_front());
    m_press = 0;
    if (seen_q.size() >= DEB) begin
      all_same = 1;
      for (int i = 0; i < DEB; i++)
        if (seen_q[seen_q.size()-1-i] != s) all_same = 0;
      if (all_same && s != m_level) begin
        m_level = s;
        m_press = s;
      end
    end
  endtask

  task automatic cyc(input bit b, input bit ft);
    start_btn  = b;
    frame_tick = ft;
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic set_road(input int l, input int r, input int x);
    road_left  = 10'(l);
    road_right = 10'(r);
    player_x   = 10'(x);
  endtask

  task automatic do_reset(input bit b);
    start_btn = b;
    rst = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start_btn = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (dut_vec !== 12'h000) begin
      n_bad++; $display("FAIL reset_outputs: got %h want %h", dut_vec, 12'h000);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_start();
    set_road(100, 300, 200);
    for (int i = 0; i < 10; i++) begin
      cyc(i < 2, 0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL start_glitch: got %h want %h", dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (state !== 2'd0) begin
      n_bad++; $display("FAIL start_glitch_state: got %0d want 0", state);
    end
    for (int i = 0; i < 14; i++) begin
      cyc(i < 10, 0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL start_press: got %h want %h", dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (state !== 2'd1 || running !== 1'b1) begin
      n_bad++; $display("FAIL start_run: got state %0d running %b want 1 1", state, running);
    end
  endtask

  task automatic test_crash();
    set_road(100, 300, 301);
    for (int i = 0; i < 9; i++) begin
      cyc(0, (i % 3) == 2);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL crash_seq: got %h want %h", dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (dead !== 1'b1 || state !== 2'd2 || crash_count !== 8'd1) begin
      n_bad++;
      $display("FAIL crash_first: got dead %b state %0d count %0d want 1 2 1", dead, state, crash_count);
    end
    cyc(0, 0);
    n_vec++;
    if (dead !== 1'b0) begin
      n_bad++; $display("FAIL crash_pulse_width: got dead %b want 0", dead);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 24; i++) begin
      cyc(i < 8, (i % 4) == 3);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL hold_seq: got %h want %h", dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (state !== 2'd0) begin
      n_bad++; $display("FAIL hold_expire: got state %0d want 0", state);
    end
    for (int i = 0; i < 13; i++) begin
      cyc(i < 10, 0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL hold_restart: got %h want %h", dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (running !== 1'b1) begin
      n_bad++; $display("FAIL hold_rerun: got running %b want 1", running);
    end
  endtask

  task automatic test_grace();
    int xs[7] = '{99, 99, 150, 99, 99, 100, 300};
    bit saw_dead = 0;
    for (int k = 0; k < 11; k++) begin
      set_road(100, 300, (k < 7) ? xs[k] : ((k % 2) ? 100 : 300));
      cyc(0, 0);
      cyc(0, 1);
      saw_dead |= dead;
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL grace_tick%0d: got %h want %h", k, dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (saw_dead || state !== 2'd1) begin
      n_bad++; $display("FAIL grace_no_crash: got dead_seen %b state %0d want 0 1", saw_dead, state);
    end
  endtask

  task automatic test_boundary();
    int k = 0;
    set_road(200, 100, 150);
    for (int i = 0; i < 30; i++) begin
      cyc(0, (i % 3) == 2);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL boundary_inverted: got %h want %h", dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (state !== 2'd0 || crash_count !== 8'd2) begin
      n_bad++; $display("FAIL boundary_crash: got state %0d count %0d want 0 2", state, crash_count);
    end
    while (!m_press && k < 20) begin
      cyc(1, 0);
      k++;
    end
    if (!m_press) begin
      n_vec++; n_bad++; $display("FAIL boundary_press_timeout: got no press want press within 20");
    end
    cyc(1, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, i % 2);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL boundary_coincide: got %h want %h", dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (state !== 2'd1 || dead !== 1'b0) begin
      n_bad++; $display("FAIL boundary_tick_ignored: got state %0d dead %b want 1 0", state, dead);
    end
    cyc(0, 0);
    cyc(0, 1);
    n_vec++;
    if (dead !== 1'b1 || crash_count !== 8'd3) begin
      n_bad++; $display("FAIL boundary_third_tick: got dead %b count %0d want 1 3", dead, crash_count);
    end
  endtask

  task automatic test_reset_mid_hold();
    int guard = 0;
    int first_run = 0;
    set_road(100, 300, 301);
    while ((m_crash < 7 || m_state != 2) && guard < 600) begin
      cyc(m_state == 0, (m_state != 0) && (guard % 3 == 0));
      guard++;
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL mid_hold_build: got %h want %h", dut_vec, exp_vec());
      end
    end
    cyc(0, 0);
    n_vec++;
    if (state !== 2'd2 || crash_count !== 8'd7) begin
      n_bad++; $display("FAIL mid_hold_setup: got state %0d count %0d want 2 7", state, crash_count);
    end
    start_btn = 1'b1;
    rst = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (dut_vec !== 12'h000) begin
      n_bad++; $display("FAIL mid_hold_async_reset: got %h want %h", dut_vec, 12'h000);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1, 0);
      if (running === 1'b1 && first_run == 0) first_run = i;
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL mid_hold_release: got %h want %h", dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (first_run != 7) begin
      n_bad++; $display("FAIL release_press_latency: got RUN at edge %0d want 7", first_run);
    end
  endtask

  task automatic test_random();
    bit b = 0;
    int rl = 100, rr = 300;
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) begin
        rl = $urandom_range(50, 450);
        rr = ($urandom_range(0, 7) == 0) ? rl - $urandom_range(1, 40) : rl + $urandom_range(0, 400);
      end
      set_road(rl, rr, $urandom_range(0, 1) ? rl + $urandom_range(0, 6) - 3 : rr + $urandom_range(0, 6) - 3);
      if ($urandom_range(0, 11) == 0) b = ~b;
      if ($urandom_range(0, 699) == 0) begin
        do_reset(b);
        n_vec++;
        if (dut_vec !== 12'h000) begin
          n_bad++; $display("FAIL random_reset: got %h want %h", dut_vec, 12'h000);
        end
      end
      cyc(b, $urandom_range(0, 2) == 0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_start();
    test_crash();
    test_hold();
    test_grace();
    test_boundary();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
